// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared states, credit ops and coin constants for the vending controller
package vend_pkg;

  localparam int unsigned PRICE_DEFAULT = 3;
  localparam int unsigned NICKEL_VAL    = 1;
  localparam int unsigned DIME_VAL      = 2;

  // Three bits leave spare encodings so a corrupted state can be caught and recovered.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_VEND    = 3'd2,
    S_CHANGE  = 3'd3
  } vend_state_e;

  typedef enum logic [2:0] {
    OP_HOLD      = 3'd0,
    OP_ADD_N     = 3'd1,
    OP_ADD_D     = 3'd2,
    OP_SUB_PRICE = 3'd3,
    OP_SUB_ONE   = 3'd4,
    OP_CLEAR     = 3'd5
  } credit_op_e;

endpackage

// File: rtl/vend_credit.sv
// rtl/vend_credit.sv - credit register updated by single-cycle strobes from the FSM
module vend_credit
  import vend_pkg::*;
#(
  parameter int unsigned PRICE = PRICE_DEFAULT,
  parameter int unsigned CW    = 5
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  credit_op_e    op_i,
  output logic [CW-1:0] credit_o
);

  localparam logic [CW-1:0] PRICE_W  = CW'(PRICE);
  localparam logic [CW-1:0] NICKEL_W = CW'(NICKEL_VAL);
  localparam logic [CW-1:0] DIME_W   = CW'(DIME_VAL);
  localparam logic [CW-1:0] ONE_W    = CW'(1);

  logic [CW-1:0] credit_q, credit_d;

  // Subtractions clamp at zero so a stray strobe can never wrap the credit.
  always_comb begin
    credit_d = credit_q;
    case (op_i)
      OP_ADD_N:     credit_d = credit_q + NICKEL_W;
      OP_ADD_D:     credit_d = credit_q + DIME_W;
      OP_SUB_PRICE: credit_d = (credit_q >= PRICE_W) ? credit_q - PRICE_W : '0;
      OP_SUB_ONE:   credit_d = (credit_q != '0) ? credit_q - ONE_W : '0;
      OP_CLEAR:     credit_d = '0;
      default:      credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credit_q <= '0;
    end else begin
      credit_q <= credit_d;
    end
  end

  assign credit_o = credit_q;

endmodule

// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - coin-collect / vend / change FSM with registered request outputs
module vend_controller
  import vend_pkg::*;
#(
  parameter int unsigned PRICE = PRICE_DEFAULT,
  parameter int unsigned CW    = 5
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          N,
  input  logic          D,
  input  logic          Cancel,
  input  logic          VendAck,
  input  logic          ChgAck,
  output logic          VendReq,
  output logic          ChgReq,
  output logic          CoinRej,
  output logic [CW-1:0] Credit,
  output logic          Busy
);

  localparam logic [CW:0]   PRICE_X  = (CW+1)'(PRICE);
  localparam logic [CW:0]   NICKEL_X = (CW+1)'(NICKEL_VAL);
  localparam logic [CW:0]   DIME_X   = (CW+1)'(DIME_VAL);
  localparam logic [CW-1:0] PRICE_W  = CW'(PRICE);
  localparam logic [CW-1:0] ONE_W    = CW'(1);

  vend_state_e   state_q, state_d;
  credit_op_e    op;
  logic          reject_d;
  logic          vend_req_q, chg_req_q, coin_rej_q, busy_q;
  logic [CW:0]   credit_x;
  logic [CW:0]   coin_sum;
  logic          coin_one;

  assign credit_x = {1'b0, Credit};
  assign coin_one = N ^ D;
  assign coin_sum = credit_x + (N ? NICKEL_X : DIME_X);

  always_comb begin
    state_d  = state_q;
    op       = OP_HOLD;
    reject_d = 1'b0;
    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (Cancel && state_q == S_COLLECT) begin
          state_d  = S_CHANGE;
          reject_d = N | D;
        end else if (N && D) begin
          reject_d = 1'b1;
        end else if (coin_one) begin
          op      = N ? OP_ADD_N : OP_ADD_D;
          state_d = (coin_sum >= PRICE_X) ? S_VEND : S_COLLECT;
        end
      end
      S_VEND: begin
        reject_d = N | D;
        if (VendAck) begin
          op      = OP_SUB_PRICE;
          state_d = (Credit > PRICE_W) ? S_CHANGE : S_IDLE;
        end
      end
      S_CHANGE: begin
        reject_d = N | D;
        if (ChgAck) begin
          op = OP_SUB_ONE;
          if (Credit <= ONE_W) state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        op      = OP_CLEAR;
      end
    endcase
  end

  // Request outputs are flopped from the next state so they change exactly with the state.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= S_IDLE;
      vend_req_q <= 1'b0;
      chg_req_q  <= 1'b0;
      coin_rej_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vend_req_q <= (state_d == S_VEND);
      chg_req_q  <= (state_d == S_CHANGE);
      coin_rej_q <= reject_d;
      busy_q     <= (state_d != S_IDLE);
    end
  end

  vend_credit #(
    .PRICE (PRICE),
    .CW    (CW)
  ) u_credit (
    .clk_i    (Clock),
    .rst_ni   (Resetn),
    .op_i     (op),
    .credit_o (Credit)
  );

  assign VendReq = vend_req_q;
  assign ChgReq  = chg_req_q;
  assign CoinRej = coin_rej_q;
  assign Busy    = busy_q;

endmodule

// File: tb/tb_vend_controller.sv
// tb/tb_vend_controller.sv - randomized scoreboard bench for vend_controller against a credit-ledger model
module tb_vend_controller;

  localparam int PRICE = 3;
  localparam int CW    = 5;

  logic          Clock;
  logic          Resetn;
  logic          N, D, Cancel, VendAck, ChgAck;
  logic          VendReq, ChgReq, CoinRej, Busy;
  logic [CW-1:0] Credit;

  typedef struct {
    int credit;
    bit vend;
    bit chg;
    bit rej;
    bit busy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Ledger view: money held, whether an item is owed, whether change is owed.
  int m_credit;
  bit m_vend;
  bit m_chg;
  bit pending_rel;

  vend_controller #(.PRICE(PRICE), .CW(CW)) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .N       (N),
    .D       (D),
    .Cancel  (Cancel),
    .VendAck (VendAck),
    .ChgAck  (ChgAck),
    .VendReq (VendReq),
    .ChgReq  (ChgReq),
    .CoinRej (CoinRej),
    .Credit  (Credit),
    .Busy    (Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge Clock) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("Credit",  int'(Credit),  mon_e.credit);
      check("VendReq", int'(VendReq), int'(mon_e.vend));
      check("ChgReq",  int'(ChgReq),  int'(mon_e.chg));
      check("CoinRej", int'(CoinRej), int'(mon_e.rej));
      check("Busy",    int'(Busy),    int'(mon_e.busy));
    end
  end

  task automatic model_step(input bit n, input bit d, input bit c, input bit va, input bit ca,
                            output exp_t e);
    e.rej = 1'b0;
    if (m_vend) begin
      e.rej = n | d;
      if (va) begin
        m_credit = m_credit - PRICE;
        m_vend   = 1'b0;
        m_chg    = (m_credit > 0);
      end
    end else if (m_chg) begin
      e.rej = n | d;
      if (ca) begin
        m_credit = m_credit - 1;
        if (m_credit == 0) m_chg = 1'b0;
      end
    end else if (c && m_credit > 0) begin
      m_chg = 1'b1;
      e.rej = n | d;
    end else if (n && d) begin
      e.rej = 1'b1;
    end else if (n || d) begin
      m_credit = m_credit + (n ? 1 : 2);
      if (m_credit >= PRICE) m_vend = 1'b1;
    end
    e.credit = m_credit;
    e.vend   = m_vend;
    e.chg    = m_chg;
    e.busy   = m_vend || m_chg || (m_credit > 0);
  endtask

  task automatic cycle(input bit n, input bit d, input bit c, input bit va, input bit ca);
    exp_t e;
    @(negedge Clock);
    if (pending_rel) begin
      Resetn      = 1'b1;
      pending_rel = 1'b0;
    end
    N = n; D = d; Cancel = c; VendAck = va; ChgAck = ca;
    model_step(n, d, c, va, ca, e);
    exp_q.push_back(e);
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) cycle(0, 0, 0, 0, 0);
  endtask

  // Asserts reset between edges, checks outputs fall before any clock, leaves release to the next cycle.
  task automatic do_reset();
    @(posedge Clock);
    #2;
    N = 0; D = 0; Cancel = 0; VendAck = 0; ChgAck = 0;
    Resetn = 1'b0;
    #1;
    check("rst Credit",  int'(Credit),  0);
    check("rst VendReq", int'(VendReq), 0);
    check("rst ChgReq",  int'(ChgReq),  0);
    check("rst CoinRej", int'(CoinRej), 0);
    check("rst Busy",    int'(Busy),    0);
    m_credit = 0; m_vend = 0; m_chg = 0;
    exp_q.delete();
    pending_rel = 1'b1;
  endtask

  initial begin
    N = 0; D = 0; Cancel = 0; VendAck = 0; ChgAck = 0;
    Resetn = 1'b0;
    m_credit = 0; m_vend = 0; m_chg = 0;
    pending_rel = 1'b1;
    #1;
    check("init Credit",  int'(Credit),  0);
    check("init VendReq", int'(VendReq), 0);
    check("init ChgReq",  int'(ChgReq),  0);
    check("init CoinRej", int'(CoinRej), 0);
    check("init Busy",    int'(Busy),    0);

    // First edge after release takes a coin; then three nickels reach price exactly.
    cycle(1, 0, 0, 0, 0);
    do_reset();
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    idle_cycles(2);

    // Two dimes overpay by one nickel of change.
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1);
    idle_cycles(1);

    // Dime then cancel refunds two nickels.
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    idle_cycles(1);

    // Simultaneous coins, coin during vend, stray acks and cancel while idle.
    cycle(1, 1, 0, 0, 0);
    cycle(0, 0, 1, 1, 1);
    cycle(0, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(1, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);

    // Dispenser stalls for ten cycles.
    cycle(0, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    idle_cycles(10);
    cycle(0, 0, 0, 1, 0);

    // Reset in the middle of a refund, then a fresh nickel.
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    do_reset();
    cycle(1, 0, 0, 0, 0);
    idle_cycles(2);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 4) < 2);
    end

    @(posedge Clock);
    #2;
    check("queue drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_controller.md
VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 Parameter: PRICE, 3, item price in nickels (5-cent units); legal range 1..15.
REQ-002 Parameter: CW, 5, credit register width in bits.
REQ-003 Port: Clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port: Resetn  input  1  asynchronous, active-low reset.
REQ-005 Port: N  input  1  nickel-accepted pulse, one cycle per coin.
REQ-006 Port: D  input  1  dime-accepted pulse, one cycle per coin.
REQ-007 Port: Cancel  input  1  customer refund request, one-cycle pulse.
REQ-008 Port: VendAck  input  1  dispenser acknowledges that the item was released.
REQ-009 Port: ChgAck  input  1  change unit acknowledges that one nickel was paid out.
REQ-010 Port: VendReq  output  1  request that the dispenser release one item.
REQ-011 Port: ChgReq  output  1  request that the change unit pay out one nickel.
REQ-012 Port: CoinRej  output  1  one-cycle pulse telling the coin mechanism to return the coin just inserted.
REQ-013 Port: Credit  output  CW  current credit in nickels.
REQ-014 Port: Busy  output  1  high whenever the state is not S_IDLE.

Function
REQ-015 The FSM SHALL have exactly four states: S_IDLE (credit 0), S_COLLECT, S_VEND and S_CHANGE.
REQ-016 VendReq, ChgReq and Busy SHALL be registered state decodes: VendReq=(S_VEND), ChgReq=(S_CHANGE), Busy=(not S_IDLE).
REQ-017 In S_IDLE or S_COLLECT, a lone N SHALL add 1 to Credit and a lone D SHALL add 2, effective on the same edge.
REQ-018 After an accepted coin, if the new credit >= PRICE the next state SHALL be S_VEND; otherwise it SHALL be S_COLLECT.
REQ-019 If N and D are high in the same cycle, both coins SHALL be rejected: CoinRej=1 for the following cycle, and Credit and state unchanged.
REQ-020 Any N or D arriving in S_VEND or S_CHANGE SHALL be rejected the same way.
REQ-021 Cancel in S_COLLECT SHALL move the FSM to S_CHANGE, refunding the full credit; any coin in that same cycle SHALL be rejected.
REQ-022 Cancel in S_IDLE, S_VEND or S_CHANGE SHALL be ignored.
REQ-023 In S_VEND, VendReq SHALL stay high and Credit SHALL stay stable until VendAck is sampled high.
REQ-024 On that VendAck edge, Credit SHALL drop by PRICE; the next state SHALL be S_CHANGE if the remainder is > 0, else S_IDLE.
REQ-025 In S_CHANGE, each cycle with ChgAck high SHALL decrement Credit by 1.
REQ-026 The ack that brings Credit to 0 SHALL also move the FSM to S_IDLE, so ChgReq falls on that edge.
REQ-027 VendAck sampled outside S_VEND, and ChgAck sampled outside S_CHANGE, SHALL be ignored.
REQ-028 Credit SHALL never exceed PRICE+1 and SHALL never underflow.
REQ-029 The unreachable state encoding SHALL recover to S_IDLE with Credit cleared.

Reset
REQ-030 While Resetn=0, the block SHALL immediately force state S_IDLE, Credit=0, VendReq=0, ChgReq=0, CoinRej=0 and Busy=0, independent of Clock.
REQ-031 Reset asserted mid-vend or mid-change SHALL abandon the transaction; no request SHALL be reissued after reset.
REQ-032 The first edge after Resetn rises SHALL be able to accept a coin.

Structure
REQ-033 The state encoding, the PRICE default and the coin-value constants (nickel=1, dime=2) SHALL live in the shared package vend_pkg.
REQ-034 Credit arithmetic SHALL be one sub-module, vend_credit (add 1/2, subtract PRICE, subtract 1, clear), driven by FSM strobes.

Verification (PRICE=3)
REQ-035 Pulses N,N,N -> Credit 1,2,3; VendReq high after the third edge; VendAck -> Credit 0, S_IDLE, ChgReq never asserted.
REQ-036 Pulses D,D -> Credit 4, VendReq; VendAck -> Credit 1, ChgReq=1; ChgAck -> Credit 0, ChgReq=0, Busy=0.
REQ-037 D then Cancel -> S_CHANGE with Credit 2; two ChgAck cycles -> Credit 0 and S_IDLE; a VendReq pulse never appears.
REQ-038 N and D in the same cycle -> CoinRej one cycle, Credit 0; D during S_VEND -> CoinRej, Credit unchanged.
REQ-039 VendAck withheld for 10 cycles -> VendReq held high for all 10, Credit stable at 3.
REQ-040 Resetn pulled low asynchronously in S_CHANGE with Credit 2 -> all outputs 0 before the next Clock edge; after release, N -> Credit 1.
